// File: rtl/imem_resp.sv
// Instruction-memory responder: fixed-latency word fetch with access-fault detection
// and a backdoor load port. BASE_ADDR is expected to be word-aligned.
module imem_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY = 2,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_idx,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [15:0]           err_cnt
);

  // state | meaning
  // IDLE  | no transaction, ready for a request
  // BUSY  | request latched, wait counter running
  // RESP  | response presented, waiting for resp_ready
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-3:0] BASE_WORD = BASE_ADDR[ADDR_WIDTH-1:2];

  state_t                state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      pend_idx;
  logic                  pend_fault;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-3:0] word_off;
  logic                  req_fault;
  logic [IDX_W-1:0]      req_idx;
  logic                  accept;
  logic                  resp_fire;

  // Word offset high bits nonzero means the address lies past the array end.
  assign word_off  = req_addr[ADDR_WIDTH-1:2] - BASE_WORD;
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                     (word_off[ADDR_WIDTH-3:IDX_W] != '0);
  assign req_idx   = word_off[IDX_W-1:0];

  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = resp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      err_cnt    <= '0;
      pend_idx   <= '0;
      pend_fault <= 1'b0;
    end else begin
      if (resp_fire && resp_err && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;

      if (accept) begin
        pend_idx   <= req_idx;
        pend_fault <= req_fault;
        if (LATENCY == 1) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_data  <= req_fault ? '0 : mem[req_idx];
          resp_err   <= req_fault;
        end else begin
          state      <= BUSY;
          cnt        <= LOAD_CNT;
          resp_valid <= 1'b0;
        end
      end else begin
        case (state)
          BUSY: begin
            if (cnt == 4'd1) begin
              cnt        <= '0;
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= pend_fault ? '0 : mem[pend_idx];
              resp_err   <= pend_fault;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          RESP: begin
            if (resp_ready) begin
              state      <= IDLE;
              resp_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Array is never reset; a load on the sampling edge lands after the read.
  always_ff @(posedge clk) begin
    if (ld_en && !rst)
      mem[ld_idx] <= ld_data;
  end

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: one LATENCY=2 instance and one LATENCY=1 instance,
// expected responses queued at accept and compared when presented.
module tb_imem_resp;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, ld_en;
  logic [31:0] req_addr, resp_data, ld_data;
  logic [11:0] ld_idx;
  logic [15:0] err_cnt;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err, b_ld_en;
  logic [31:0] b_req_addr, b_resp_data, b_ld_data;
  logic [11:0] b_ld_idx;
  logic [15:0] b_err_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];

  imem_resp #(.LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data), .err_cnt(err_cnt)
  );

  imem_resp #(.LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_err(b_resp_err), .ld_en(b_ld_en), .ld_idx(b_ld_idx),
    .ld_data(b_ld_data), .err_cnt(b_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] addr, input bit sel_b);
    exp_t e;
    int   idx;
    e.err  = 1'b0;
    e.data = 32'h0;
    if (addr[1:0] != 2'b00 || addr < 32'h8000_0000 || addr >= 32'h8000_4000) begin
      e.err = 1'b1;
    end else begin
      idx = int'((addr - 32'h8000_0000) >> 2);
      e.data = sel_b ? mdl_b[idx] : mdl_a[idx];
    end
    return e;
  endfunction

  task automatic load(input bit sel_b, input int idx, input logic [31:0] data);
    if (sel_b) begin
      b_ld_en = 1'b1; b_ld_idx = 12'(idx); b_ld_data = data;
    end else begin
      ld_en = 1'b1; ld_idx = 12'(idx); ld_data = data;
    end
    tick;
    ld_en = 1'b0;
    b_ld_en = 1'b0;
    if (sel_b) mdl_b[idx] = data;
    else       mdl_a[idx] = data;
  endtask

  task automatic pop_cmp_a(input string tag);
    exp_t e;
    chk({tag, "_sbq"}, 32'(q_a.size()), 32'd1);
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      chk({tag, "_data"}, resp_data, e.data);
      chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
    end
  endtask

  // Full LATENCY=2 fetch with immediate handshake.
  task automatic a_fetch(input logic [31:0] addr, input string tag);
    req_valid = 1'b1;
    req_addr  = addr;
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    tick;
    q_a.push_back(predict(addr, 1'b0));
    req_valid = 1'b0;
    chk({tag, "_v_early"}, {31'd0, resp_valid}, 32'd0);
    tick;
    chk({tag, "_v_lat"}, {31'd0, resp_valid}, 32'd1);
    pop_cmp_a(tag);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({tag, "_v_done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  logic [31:0] b_addrs [4];
  exp_t        e_hold;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    ld_en = 1'b0; ld_idx = 12'h0; ld_data = 32'h0;
    b_req_valid = 1'b0; b_req_addr = 32'h0; b_resp_ready = 1'b0;
    b_ld_en = 1'b0; b_ld_idx = 12'h0; b_ld_data = 32'h0;
    tick;
    tick;
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_errcnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_b_valid", {31'd0, b_resp_valid}, 32'd0);
    rst = 1'b0;
    chk("rdy_after_rst", {31'd0, req_ready}, 32'd1);
    chk("b_rdy_after_rst", {31'd0, b_req_ready}, 32'd1);

    load(0, 0, 32'h0000_0413);
    load(0, 1, 32'h0000_0513);
    load(0, 2, 32'h00a0_0093);
    load(0, 4095, 32'hfff0_0f13);
    load(1, 0, 32'h1111_0001);
    load(1, 1, 32'h2222_0002);
    load(1, 2, 32'h3333_0003);

    // Basic fetches and access faults
    a_fetch(32'h8000_0000, "f0");
    a_fetch(32'h8000_0004, "f1");
    a_fetch(32'h8000_3ffc, "f_last");
    a_fetch(32'h8000_0002, "mis");
    chk("errcnt_1", {16'd0, err_cnt}, 32'd1);
    a_fetch(32'h8000_4000, "oor");
    chk("errcnt_2", {16'd0, err_cnt}, 32'd2);
    a_fetch(32'h7fff_fffc, "below");
    chk("errcnt_3", {16'd0, err_cnt}, 32'd3);

    // Response stall: outputs hold, new requests are refused
    req_valid = 1'b1;
    req_addr  = 32'h8000_0008;
    tick;
    q_a.push_back(predict(32'h8000_0008, 1'b0));
    req_addr = 32'h8000_0000;
    tick;
    e_hold = q_a[0];
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_data", resp_data, e_hold.data);
      chk("stall_err", {31'd0, resp_err}, {31'd0, e_hold.err});
      chk("stall_rdy", {31'd0, req_ready}, 32'd0);
      tick;
    end
    req_valid = 1'b0;
    pop_cmp_a("stall_end");
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("stall_idle_v", {31'd0, resp_valid}, 32'd0);
    chk("stall_idle_rdy", {31'd0, req_ready}, 32'd1);

    // Reset during BUSY drops the transaction; loads under reset are ignored
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    tick;
    req_valid = 1'b0;
    rst = 1'b1;
    ld_en = 1'b1; ld_idx = 12'd0; ld_data = 32'hdead_beef;
    tick;
    rst = 1'b0;
    ld_en = 1'b0;
    chk("rst_mid_rdy", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_novalid", {31'd0, resp_valid}, 32'd0);
      tick;
    end
    chk("rst_mid_errcnt", {16'd0, err_cnt}, 32'd0);
    a_fetch(32'h8000_0000, "post_rst");

    // Load on the RESP-entry edge is not seen
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    tick;
    q_a.push_back(predict(32'h8000_0004, 1'b0));
    req_valid = 1'b0;
    ld_en = 1'b1; ld_idx = 12'd1; ld_data = 32'h1111_1111;
    tick;
    ld_en = 1'b0;
    mdl_a[1] = 32'h1111_1111;
    chk("rbw_valid", {31'd0, resp_valid}, 32'd1);
    pop_cmp_a("rbw_same");
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;

    // Load one edge earlier (on the accept edge) is seen
    req_valid = 1'b1;
    req_addr  = 32'h8000_0008;
    ld_en = 1'b1; ld_idx = 12'd2; ld_data = 32'h2222_2222;
    tick;
    mdl_a[2] = 32'h2222_2222;
    q_a.push_back(predict(32'h8000_0008, 1'b0));
    req_valid = 1'b0;
    ld_en = 1'b0;
    tick;
    chk("rbw_early_valid", {31'd0, resp_valid}, 32'd1);
    pop_cmp_a("rbw_early");
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    a_fetch(32'h8000_0004, "reread1");

    // LATENCY=1 back-to-back stream
    b_addrs[0] = 32'h8000_0000;
    b_addrs[1] = 32'h8000_0004;
    b_addrs[2] = 32'h8000_0008;
    b_addrs[3] = 32'h8000_000d;
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_req_addr = b_addrs[i];
      tick;
      q_b.push_back(predict(b_addrs[i], 1'b1));
      chk("b2b_valid", {31'd0, b_resp_valid}, 32'd1);
      chk("b2b_rdy", {31'd0, b_req_ready}, 32'd1);
      chk("b2b_sbq", 32'(q_b.size()), 32'd1);
      if (q_b.size() != 0) begin
        e_hold = q_b.pop_front();
        chk("b2b_data", b_resp_data, e_hold.data);
        chk("b2b_err", {31'd0, b_resp_err}, {31'd0, e_hold.err});
      end
    end
    b_req_valid = 1'b0;
    tick;
    b_resp_ready = 1'b0;
    chk("b2b_idle", {31'd0, b_resp_valid}, 32'd0);
    chk("b2b_errcnt", {16'd0, b_err_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
